range_seq_driver: RTL
=====================

Name: range_seq_driver

Overview:
- Initiator side of the go/finish range-finder protocol.
- Buffers a host-loaded sequence of WIDTH-bit samples, then plays it out one sample per clock as data_out with go/finish framing.
- Captures the range/debug_error result returned by the downstream range finder.
- Sits between the chip IO pins and a range finder instance; serves as an on-chip stimulus source and self-test harness.

Parameters:
- WIDTH, 8, sample and range width in bits.
- DEPTH, 16, maximum samples per sequence (power of two, at least 2).

Ports:
- clock  input  1  sole clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  load wr_data into the buffer at the write pointer.
- wr_data  input  WIDTH  sample to load.
- clear  input  1  empty the buffer and clear all sticky flags.
- start  input  1  begin playback of the buffered sequence.
- data_out  output  WIDTH  sample driven to the range finder.
- go  output  1  first-sample marker.
- finish  output  1  end-of-sequence marker.
- range_in  input  WIDTH  range result from the range finder.
- error_in  input  1  debug_error from the range finder.
- busy  output  1  playback in progress.
- result  output  WIDTH  captured range.
- result_valid  output  1  result holds a capture; cleared on the next start.
- rf_error  output  1  captured error_in.
- overflow  output  1  sticky: write dropped because the buffer was full.
- count  output  $clog2(DEPTH)+1  number of buffered samples.

Behaviour:
- Reset (reset_n=0, async assert, sync release):
  - All outputs 0; state IDLE; count 0; buffer contents don't-care.
- States: IDLE -> GO -> STREAM -> FINISH -> CAPTURE -> IDLE.
- IDLE:
  - wr_en writes buffer[count] and count++.
  - wr_en with count==DEPTH drops the write and sets overflow.
  - clear sets count=0 and clears overflow, result_valid, rf_error. clear takes priority over wr_en in the same cycle.
  - start with count>=1 goes to GO and clears result_valid.
  - start with count==0 is ignored, with no flag change.
- GO (1 cycle):
  - go=1, data_out=buffer[0], busy=1.
  - Next state is STREAM if count>1, else FINISH.
- STREAM:
  - data_out=buffer[i] for i=1..count-1, one per cycle.
  - Leave for FINISH after i=count-1.
- FINISH (1 cycle):
  - finish=1, data_out holds the last sample.
  - go and finish are never asserted together.
- CAPTURE (1 cycle, the cycle after finish):
  - Sample range_in into result and error_in into rf_error; set result_valid=1.
  - Return to IDLE.
- busy=1 in every state except IDLE.
- Outputs outside their states: go, finish and data_out are registered outputs. data_out=0, go=0 and finish=0 in IDLE and CAPTURE.
- Ignored inputs:
  - wr_en, clear and start are ignored while busy.
  - Buffer contents and count are preserved after playback, so start replays the same sequence.
- Latency: start at cycle t gives go at t+1 and finish at t+count+1. result_valid rises at t+count+3 (registered, visible the cycle after CAPTURE).
- Reset mid-playback: immediate return to IDLE; go/finish drop asynchronously; count returns to 0.

Optional Feature:
- Macro: RANGE_SELFCHECK_EN.
- When defined:
  - The block tracks the running max and min of the samples as played out.
  - In CAPTURE it compares (max-min), computed in WIDTH bits and unsigned, with range_in.
  - Adds output port mismatch (1 bit): set in CAPTURE on inequality, cleared on start, clear or reset.
- When undefined: no mismatch port and no max/min registers.

Decomposition:
- Shared package range_pkg holds:
  - state enum rsd_state_t (IDLE, GO, STREAM, FINISH, CAPTURE);
  - localparam RSD_DEPTH_DEFAULT;
  - helper function range_of(max, min).
- One sub-module, rsd_buffer: DEPTH x WIDTH register array with write pointer, count, full/empty, and a read port indexed by the FSM.

Test Plan:
- Load 3, 9, 5, start.
  - Expected: go with 3; data 9 then 5; finish with data_out=5.
  - Drive range_in=6 on the capture cycle: result=6, result_valid=1, busy=0; start to go is 1 cycle.
- Load a single sample 7, start.
  - Expected: go cycle, then finish on the very next cycle; no STREAM cycles; go and finish never high together.
- Write 17 samples with DEPTH=16.
  - Expected: count=16, overflow=1.
  - clear then gives count=0, overflow=0.
- start with an empty buffer.
  - Expected: busy stays 0; go, finish and result_valid unchanged.
- Assert reset_n=0 mid-STREAM.
  - Expected: go, finish, busy and data_out go to 0 without waiting for a clock edge; count=0.
  - After release, wr_en and start work normally.
- With RANGE_SELFCHECK_EN, play 10, 200, 50 and return range_in=190.
  - Expected: mismatch=0.
  - Returning 189 instead: mismatch=1 and rf_error mirrors error_in.

Source files
------------

// File: rtl/range_pkg.sv
// Shared types and helpers for the range sequence driver: playback FSM states,
// the default buffer depth and the max/min range helper.
package range_pkg;

  localparam int RSD_DEPTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    GO,
    STREAM,
    FINISH,
    CAPTURE
  } rsd_state_t;

  // Callers keep max_v >= min_v, so truncating the result to the sample width
  // gives the unsigned WIDTH-bit difference.
  function automatic logic [31:0] range_of(input logic [31:0] max_v, input logic [31:0] min_v);
    return max_v - min_v;
  endfunction

endpackage

// File: rtl/rsd_buffer.sv
// Sample buffer for range_seq_driver: DEPTH x WIDTH register array, appended at
// the count position, read combinationally at an index chosen by the FSM.
module rsd_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     clr_i,
  input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_idx_i];

  // NOTE: the sample array has no reset; only count says which entries are
  // meaningful, so clearing the storage would buy nothing.
  always_ff @(posedge clk) begin
    if (we_i && !full_o) begin
      mem_q[count_q[IW-1:0]] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (we_i && !full_o) begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/range_seq_driver.sv
// Go/finish initiator: buffers host samples, replays them with go/finish framing
// and captures the range finder's reply. Define RANGE_SELFCHECK_EN to add a
// max/min self-check with a mismatch output.
module range_seq_driver
  import range_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = RSD_DEPTH_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   clear,
  input  logic                   start,
  output logic [WIDTH-1:0]       data_out,
  output logic                   go,
  output logic                   finish,
  input  logic [WIDTH-1:0]       range_in,
  input  logic                   error_in,
  output logic                   busy,
  output logic [WIDTH-1:0]       result,
  output logic                   result_valid,
  output logic                   rf_error,
  output logic                   overflow,
`ifdef RANGE_SELFCHECK_EN
  output logic                   mismatch,
`endif
  output logic [$clog2(DEPTH):0] count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  rsd_state_t       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             go_q, go_d;
  logic             finish_q, finish_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] result_q;
  logic             result_valid_q, rf_error_q, overflow_q;

  logic             idle, start_ok, clear_ok, wr_ok;
  logic [WIDTH-1:0] rd_data;
  logic [CW-1:0]    buf_count;
  logic             buf_full, buf_empty;

  // Host controls only act in IDLE; clear wins over both write and start.
  assign idle     = (state_q == IDLE);
  assign clear_ok = idle && clear;
  assign wr_ok    = idle && wr_en && !clear;
  assign start_ok = idle && start && !clear && !buf_empty;

  rsd_buffer #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_buffer (
    .clk      (clock),
    .rst_n    (reset_n),
    .we_i     (wr_ok),
    .wdata_i  (wr_data),
    .clr_i    (clear_ok),
    .rd_idx_i (idx_d),
    .rd_data_o(rd_data),
    .count_o  (buf_count),
    .full_o   (buf_full),
    .empty_o  (buf_empty)
  );

  // NOTE: state and output registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: every comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = GO;
          idx_d   = '0;
        end
      end
      GO: begin
        if (buf_count > CW'(1)) begin
          state_d = STREAM;
          idx_d   = IW'(1);
        end else begin
          state_d = FINISH;
        end
      end
      STREAM: begin
        if ({1'b0, idx_q} == buf_count - CW'(1)) begin
          state_d = FINISH;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      FINISH:  state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    go_d     = (state_d == GO);
    finish_d = (state_d == FINISH);
    data_d   = '0;
    if (state_d == GO || state_d == STREAM || state_d == FINISH) begin
      data_d = rd_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      go_q     <= 1'b0;
      finish_q <= 1'b0;
      data_q   <= '0;
    end else begin
      go_q     <= go_d;
      finish_q <= finish_d;
      data_q   <= data_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result_q       <= '0;
      result_valid_q <= 1'b0;
      rf_error_q     <= 1'b0;
      overflow_q     <= 1'b0;
    end else if (clear_ok) begin
      result_valid_q <= 1'b0;
      rf_error_q     <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      if (wr_ok && buf_full) begin
        overflow_q <= 1'b1;
      end
      if (start_ok) begin
        result_valid_q <= 1'b0;
      end
      if (state_q == CAPTURE) begin
        result_q       <= range_in;
        rf_error_q     <= error_in;
        result_valid_q <= 1'b1;
      end
    end
  end

`ifdef RANGE_SELFCHECK_EN
  logic [WIDTH-1:0] max_q, min_q;
  logic             mismatch_q;

  // Extremes follow the samples as they are driven; GO seeds both with sample 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      max_q      <= '0;
      min_q      <= '0;
      mismatch_q <= 1'b0;
    end else begin
      if (state_d == GO) begin
        max_q <= rd_data;
        min_q <= rd_data;
      end else if (state_d == STREAM) begin
        if (rd_data > max_q) max_q <= rd_data;
        if (rd_data < min_q) min_q <= rd_data;
      end
      if (clear_ok || start_ok) begin
        mismatch_q <= 1'b0;
      end else if (state_q == CAPTURE) begin
        mismatch_q <= (WIDTH'(range_of(32'(max_q), 32'(min_q))) != range_in);
      end
    end
  end

  assign mismatch = mismatch_q;
`endif

  assign data_out     = data_q;
  assign go           = go_q;
  assign finish       = finish_q;
  assign busy         = !idle;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign rf_error     = rf_error_q;
  assign overflow     = overflow_q;
  assign count        = buf_count;

endmodule
